spm_host: RTL
=============

# spm_host

Host-side transmitter/receiver for the bit-serial unsigned multiplier `spm`. It accepts a parallel multiplicand/multiplier pair over a valid/ready handshake and clears the multiplier through its active-low reset. It then shifts the multiplicand out LSB-first on `spm_x`, collects the bit-serial product from `spm_y`, and presents the full 2·BITS-bit product over a second valid/ready handshake. It sits between a bus-side client and one `spm` instance of matching width.

## Interface
- `BITS`, default 32: operand width; must equal the attached multiplier's `bits`. Product width is 2·BITS.
- `clk`  input  1  clock; all flops on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand pair valid.
- `in_ready`  output  1  block can accept operands.
- `in_x`  input  BITS  multiplicand, serialized to the multiplier.
- `in_a`  input  BITS  multiplier, presented in parallel.
- `out_valid`  output  1  product valid.
- `out_ready`  input  1  consumer accepts product.
- `out_p`  output  2·BITS  product `in_x * in_a`, unsigned.
- `spm_x`  output  1  serial multiplicand bit to the multiplier's `x`.
- `spm_a`  output  BITS  latched multiplier to the multiplier's `a`.
- `spm_rst_n`  output  1  active-low clear to the multiplier's `rst`.
- `spm_y`  input  1  serial product bit from the multiplier's `y`.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- **IDLE**
  - `in_ready` = 1 only in IDLE.
  - On `in_valid & in_ready`: latch `in_x` into a shift register and `in_a` into `spm_a`; go to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `spm_rst_n` = 0 and `spm_x` = 0; clears all multiplier carry and sum flops.
  - Counter `cnt` ← 0; go to SHIFT.
- **SHIFT** (exactly 2·BITS+1 cycles, `cnt` = 0 … 2·BITS)
  - `spm_x` = bit `cnt` of the latched multiplicand for `cnt` < BITS; 0 for `cnt` ≥ BITS (upper zero padding).
  - The multiplier has 1-cycle latency: product bit k appears on `spm_y` the cycle after multiplicand bit k is driven.
  - For `cnt` ≥ 1, capture `spm_y` as product bit `cnt`−1 by right-shifting into the MSB of a 2·BITS register.
  - After `cnt` = 2·BITS, go to DONE.
- **DONE**
  - `out_valid` = 1; `out_p` holds the product stable.
  - On `out_ready`: go to IDLE; `out_valid` drops the next cycle.
- Arithmetic: the product is exact modulo 2^(2·BITS), i.e. no overflow is possible. `cnt` width is clog2(2·BITS+1).
- `spm_a` is held constant from acceptance until return to IDLE.
- `spm_rst_n`, `spm_x`, `out_valid` and `in_ready` are registered or pure state decodes (no combinational path from inputs) so the multiplier's asynchronous reset stays glitch-free.

## Timing
- Reset values: state IDLE, `in_ready` 1 after reset release (0 while `rst` is high), `out_valid` 0, `out_p` 0, `spm_x` 0, `spm_a` 0, `spm_rst_n` 0.
- After reset release, `spm_rst_n` = 1 in all states except CLEAR.
- Acceptance in cycle c gives:
  - CLEAR in cycle c+1;
  - multiplicand bit k driven in cycle c+2+k;
  - product bit k sampled in cycle c+3+k;
  - `out_valid` high from cycle c+3+2·BITS.
- Accept-to-valid latency is 2·BITS+3 cycles. Minimum initiation interval is 2·BITS+4 cycles, with `out_ready` tied high.
- `in_valid` while busy: ignored, no operands latched, no error.
- `out_ready` low: the block stalls in DONE indefinitely; `out_p` is stable.
- Reset mid-operation (any state): aborts immediately. Partial product is discarded, `out_valid` → 0, `spm_rst_n` → 0, back to IDLE.

## Structure
- Package `spm_host_pkg`:
  - FSM state enum;
  - `localparam` helpers for product width (2·BITS) and counter width.
- No internal sub-module. The multiplicand PISO and the product SIPO are plain shift registers inside `spm_host`.
- Bench and integration wrapper `spm_system` instantiates `spm_host` plus `spm` with matching `BITS` and wires the `spm_*` ports.

## Test plan
All scenarios use BITS = 8 with `spm_system`.
- **Basic:** `in_x`=3, `in_a`=5, `out_ready` high → `out_p`=15, `out_valid` rises exactly 19 cycles after acceptance.
- **Max operands:** `in_x`=255, `in_a`=255 → `out_p`=65025. Also `in_x`=0, `in_a`=200 → `out_p`=0.
- **Back-to-back:** `in_valid` held high with pairs (12,13), (200,7) → products 156 then 1400; `in_ready` low throughout each operation; second acceptance occurs in IDLE only.
- **Back-pressure:** 17×19 with `out_ready` low for 10 cycles after `out_valid` → `out_p`=323 held stable; single transfer when `out_ready` rises.
- **Reset mid-SHIFT:** assert `rst` at `cnt`=5 →
  - `out_valid` never rises for that operation;
  - `spm_rst_n`=0 during reset;
  - next operation 9×9 → 81.
- **Clear check:** run 255×255, then 1×1 → 1, proving CLEAR flushed the multiplier's residual carries.

Source files
------------

// File: rtl/spm_host_pkg.sv
// ============================================================================
// Module : spm_host_pkg
// Brief  : Shared FSM encoding and width helpers for the spm host.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spm_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_BITS = 32;

  function automatic int prod_width(input int bits);
    return 2 * bits;
  endfunction

  // Counter spans 0 .. 2*bits inclusive.
  function automatic int cnt_width(input int bits);
    return $clog2(2 * bits + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spm.sv
// ============================================================================
// Module : spm
// Brief  : Bit-serial unsigned multiplier; x LSB-first in, product LSB-first
//          out one cycle later. Active-low asynchronous clear on rst.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spm #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            x,
  input  logic [BITS-1:0] a,
  output logic            y
);

  logic [BITS-1:0] r_acc;
  logic            r_y;
  logic [BITS:0]   w_sum;

  // acc + a never exceeds 2^(BITS+1)-2, so the shifted sum always fits BITS.
  assign w_sum = {1'b0, r_acc} + (x ? {1'b0, a} : '0);
  assign y     = r_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_y   <= 1'b0;
    end else begin
      r_acc <= w_sum[BITS:1];
      r_y   <= w_sum[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/spm_host.sv
// ============================================================================
// Module : spm_host
// Brief  : Parallel-to-serial host for the spm multiplier with valid/ready
//          operand and product handshakes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spm_host
  import spm_host_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   in_x,
  input  logic [BITS-1:0]   in_a,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*BITS-1:0] out_p,
  output logic              spm_x,
  output logic [BITS-1:0]   spm_a,
  output logic              spm_rst_n,
  input  logic              spm_y
);

  localparam int PW = prod_width(BITS);
  localparam int CW = cnt_width(BITS);
  localparam logic [CW-1:0] C_LAST  = CW'(PW);
  localparam logic [CW-1:0] C_XBITS = CW'(BITS);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [BITS-1:0] r_x_sh;
  logic [BITS-1:0] r_spm_a;
  logic [PW-1:0]   r_p;
  logic            r_in_ready;
  logic            r_spm_rst_n;
  logic            w_accept;

  assign w_accept = in_valid & r_in_ready & (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == C_LAST) w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Handshake ready and the multiplier clear are flopped from next-state so
  // both are low in reset and spm_rst_n never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_spm_rst_n <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == ST_IDLE);
      r_spm_rst_n <= (w_next != ST_CLEAR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_x_sh  <= '0;
      r_spm_a <= '0;
      r_p     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x_sh  <= in_x;
            r_spm_a <= in_a;
          end
        end
        ST_CLEAR: r_cnt <= '0;
        ST_SHIFT: begin
          r_cnt  <= r_cnt + C_ONE;
          r_x_sh <= {1'b0, r_x_sh[BITS-1:1]};
          // spm_y lags the driven bit by one cycle; first capture at cnt=1.
          if (r_cnt != '0) r_p <= {spm_y, r_p[PW-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign spm_rst_n = r_spm_rst_n;
  assign spm_a     = r_spm_a;
  assign out_p     = r_p;
  assign out_valid = (r_state == ST_DONE);
  assign spm_x     = (r_state == ST_SHIFT) && (r_cnt < C_XBITS) && r_x_sh[0];

endmodule

`default_nettype wire
